// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  // Architectural register select (32 GPRs).
  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT,
    HALT
  } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: a load in EX whose result the DEC instruction needs.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic     MemtoReg_ex,
  input  regbits_t wsel_ex,
  input  regbits_t rs_dec,
  input  regbits_t rt_dec,
  input  logic     uses_rt_dec,
  output logic     lu_hazard
);

  // $0 is never a real dependency, so a load targeting it never stalls.
  assign lu_hazard = MemtoReg_ex && (wsel_ex != '0) &&
                     ((wsel_ex == rs_dec) || (uses_rt_dec && (wsel_ex == rt_dec)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             MemtoReg_ex,
  input  regbits_t         wsel_ex,
  input  regbits_t         rs_dec,
  input  regbits_t         rt_dec,
  input  logic             uses_rt_dec,
  input  logic             jump_ex,
  input  logic             branch_taken_mem,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  hazard_state_t    state_q, state_d;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lu_hazard;
  logic             mem_pend;

  load_use_detect u_lu (
    .MemtoReg_ex (MemtoReg_ex),
    .wsel_ex     (wsel_ex),
    .rs_dec      (rs_dec),
    .rt_dec      (rt_dec),
    .uses_rt_dec (uses_rt_dec),
    .lu_hazard   (lu_hazard)
  );

  assign mem_pend = (dmemREN_mem || dmemWEN_mem) && !dhit;

  // Next state and Mealy enables/flushes; everything defaults to frozen.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    en_ifid     = 1'b0;
    en_idex     = 1'b0;
    en_exmem    = 1'b0;
    en_memwb    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (nRST) begin
      case (state_q)
        HALT: state_d = HALT;
        // RUN, LU_STALL and MEM_WAIT share the priority chain; only LU_STALL
        // masks the load-use check so one load never gets two bubbles.
        default: begin
          if (halt_wb) begin
            state_d = HALT;
          end else if (mem_pend) begin
            state_d = MEM_WAIT;
          end else if (branch_taken_mem) begin
            {pc_en, en_ifid, en_idex, en_exmem, en_memwb} = '1;
            {flush_ifid, flush_idex, flush_exmem}         = '1;
            state_d = RUN;
          end else if (jump_ex) begin
            {pc_en, en_ifid, en_idex, en_exmem, en_memwb} = '1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_d    = RUN;
          end else if (lu_hazard && (state_q != LU_STALL)) begin
            en_idex    = 1'b1;
            flush_idex = 1'b1;
            en_exmem   = 1'b1;
            en_memwb   = 1'b1;
            state_d    = LU_STALL;
          end else if (!ihit) begin
            en_idex    = 1'b1;
            flush_idex = 1'b1;
            en_exmem   = 1'b1;
            en_memwb   = 1'b1;
            state_d    = RUN;
          end else begin
            {pc_en, en_ifid, en_idex, en_exmem, en_memwb} = '1;
            state_d = RUN;
          end
        end
      endcase
    end
  end

  // State, sticky halt flag and saturating stall counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALT);
      if (!pc_en && !halted_q && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CntOne;
      end
    end
  end

  assign halted       = halted_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic        CLK;
  logic        nRST;
  logic        ihit, dhit, dmemREN_mem, dmemWEN_mem, MemtoReg_ex;
  logic [4:0]  wsel_ex, rs_dec, rt_dec;
  logic        uses_rt_dec, jump_ex, branch_taken_mem, halt_wb;
  logic        pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idex, flush_exmem, halted;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .ihit             (ihit),
    .dhit             (dhit),
    .dmemREN_mem      (dmemREN_mem),
    .dmemWEN_mem      (dmemWEN_mem),
    .MemtoReg_ex      (MemtoReg_ex),
    .wsel_ex          (wsel_ex),
    .rs_dec           (rs_dec),
    .rt_dec           (rt_dec),
    .uses_rt_dec      (uses_rt_dec),
    .jump_ex          (jump_ex),
    .branch_taken_mem (branch_taken_mem),
    .halt_wb          (halt_wb),
    .pc_en            (pc_en),
    .en_ifid          (en_ifid),
    .en_idex          (en_idex),
    .en_exmem         (en_exmem),
    .en_memwb         (en_memwb),
    .flush_ifid       (flush_ifid),
    .flush_idex       (flush_idex),
    .flush_exmem      (flush_exmem),
    .halted           (halted),
    .stall_cycles     (stall_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed view of the nine control outputs: {pc_en,en x4,flush x3,halted}.
  function automatic logic [8:0] ctl();
    return {pc_en, en_ifid, en_idex, en_exmem, en_memwb,
            flush_ifid, flush_idex, flush_exmem, halted};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; dmemREN_mem = 1'b0; dmemWEN_mem = 1'b0;
    MemtoReg_ex = 1'b0; wsel_ex = 5'd0; rs_dec = 5'd0; rt_dec = 5'd0;
    uses_rt_dec = 1'b0; jump_ex = 1'b0; branch_taken_mem = 1'b0; halt_wb = 1'b0;
  endtask

  localparam logic [8:0] AllRun   = 9'b1_1111_000_0;
  localparam logic [8:0] Freeze   = 9'b0_0000_000_0;
  localparam logic [8:0] Bubble   = 9'b0_0111_010_0;
  localparam logic [8:0] BrFlush  = 9'b1_1111_111_0;
  localparam logic [8:0] JmpFlush = 9'b1_1111_110_0;
  localparam logic [8:0] Halted   = 9'b0_0000_000_1;

  initial begin
    idle_inputs();
    nRST = 1'b0;
    #2;
    check("reset_ctl", ctl(), Freeze);
    check("reset_cnt", stall_cycles, 16'd0);
    #10 nRST = 1'b1;   // released at t=12, away from the edge
    #1;
    check("run_ctl", ctl(), AllRun);
    check("run_cnt", stall_cycles, 16'd0);

    // Load-use on rs: one bubble, then the same DEC inputs proceed.
    MemtoReg_ex = 1'b1; wsel_ex = 5'd5; rs_dec = 5'd5;
    #1 check("lu_bubble", ctl(), Bubble);
    tick();
    check("lu_second_cycle", ctl(), AllRun);
    check("lu_cnt", stall_cycles, 16'd1);
    idle_inputs();
    tick();

    // Load waiting on dcache for three cycles.
    dmemREN_mem = 1'b1;
    #1 check("mem_freeze0", ctl(), Freeze);
    tick();
    check("mem_freeze1", ctl(), Freeze);
    tick();
    check("mem_freeze2", ctl(), Freeze);
    tick();
    dhit = 1'b1;
    #1 check("mem_dhit", ctl(), AllRun);
    check("mem_cnt", stall_cycles, 16'd4);
    tick();
    check("mem_cnt_after", stall_cycles, 16'd4);
    idle_inputs();

    // Taken branch beats a load-use hazard and skips LU_STALL.
    MemtoReg_ex = 1'b1; wsel_ex = 5'd5; rs_dec = 5'd5; branch_taken_mem = 1'b1;
    #1 check("branch_flush", ctl(), BrFlush);
    tick();
    branch_taken_mem = 1'b0;
    #1 check("branch_no_lustall", ctl(), Bubble);
    tick();
    idle_inputs();
    #1 check("after_lu_run", ctl(), AllRun);
    tick();
    check("branch_cnt", stall_cycles, 16'd5);

    // Load to $0 never stalls.
    MemtoReg_ex = 1'b1; wsel_ex = 5'd0; rs_dec = 5'd0;
    #1 check("zero_reg_no_stall", ctl(), AllRun);
    idle_inputs();

    // Jump flushes IF/ID and ID/EX only.
    jump_ex = 1'b1;
    #1 check("jump_flush", ctl(), JmpFlush);
    tick();
    idle_inputs();

    // rt dependency only counts when the instruction reads rt.
    MemtoReg_ex = 1'b1; wsel_ex = 5'd7; rt_dec = 5'd7; rs_dec = 5'd3; uses_rt_dec = 1'b1;
    #1 check("lu_rt", ctl(), Bubble);
    uses_rt_dec = 1'b0;
    #1 check("lu_rt_unused", ctl(), AllRun);
    idle_inputs();

    // icache miss inserts a bubble behind the stalled fetch.
    ihit = 1'b0;
    #1 check("imiss", ctl(), Bubble);
    tick();
    check("imiss_cnt", stall_cycles, 16'd6);
    idle_inputs();

    // Store waits on dcache, then halt arrives while in MEM_WAIT.
    dmemWEN_mem = 1'b1;
    #1 check("store_freeze", ctl(), Freeze);
    tick();
    halt_wb = 1'b1;
    #1 check("halt_cycle", ctl(), Freeze);
    tick();
    idle_inputs();
    #1 check("halted", ctl(), Halted);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_hold", ctl(), Halted);
    end
    check("halt_cnt", stall_cycles, 16'd8);

    // Reset pulse leaves HALT.
    nRST = 1'b0;
    #2;
    check("rst_pulse_ctl", ctl(), Freeze);
    check("rst_pulse_cnt", stall_cycles, 16'd0);
    nRST = 1'b1;
    #1 check("rst_pulse_run", ctl(), AllRun);

    // Counter saturates instead of wrapping.
    tick();
    ihit = 1'b0;
    for (int i = 0; i < 65541; i++) begin
      @(posedge CLK);
    end
    #1;
    check("sat_cnt", stall_cycles, 16'hFFFF);
    check("sat_ctl", ctl(), Bubble);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Decides each cycle which pipeline registers advance or flush, and when the PC updates. Covers load-use hazards the forwarding unit cannot resolve, dcache wait states, icache misses, taken branches/jumps and halt.
- Sits beside the forwarding unit in the datapath and feeds the pipeline-register enable/flush inputs.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
CNT_W, 16, width of the stall_cycles counter

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction fetch completed this cycle
dhit  input  1  data access completed this cycle
dmemREN_mem  input  1  MEM stage load request
dmemWEN_mem  input  1  MEM stage store request
MemtoReg_ex  input  1  EX stage instruction is a load
wsel_ex  input  5  EX stage destination register
rs_dec  input  5  DEC stage source register rs
rt_dec  input  5  DEC stage source register rt
uses_rt_dec  input  1  DEC stage instruction reads rt
jump_ex  input  1  jump/jr resolved in EX
branch_taken_mem  input  1  branch taken, resolved in MEM
halt_wb  input  1  halt instruction in WB
pc_en  output  1  PC update enable
en_ifid, en_idex, en_exmem, en_memwb  output  1 each  pipeline register enables
flush_ifid, flush_idex, flush_exmem  output  1 each  synchronous bubble insert (takes effect only with matching en=1)
halted  output  1  sticky halt indication
stall_cycles  output  CNT_W  count of cycles with pc_en=0 while not halted

Behaviour:
- Reset (nRST=0, async): state=RUN, halted=0, stall_cycles=0.
- Reset also forces all enables and flushes to 0 and pc_en=0 while asserted.
- Reset mid-MEM_WAIT or mid-LU_STALL returns to RUN immediately.
- FSM states: RUN, LU_STALL, MEM_WAIT, HALT.
- Outputs are combinational from state and inputs (Mealy). State, halted and counter are registered.
- mem_pend = (dmemREN_mem | dmemWEN_mem) & ~dhit.
- lu_hazard = MemtoReg_ex & (wsel_ex!=0) & (wsel_ex==rs_dec | (uses_rt_dec & wsel_ex==rt_dec)).
- Priority in RUN/LU_STALL, highest first:
  1. halt_wb: all en=0, pc_en=0; next state HALT. halted=1 from the next cycle.
  2. mem_pend: all en=0, pc_en=0 (full freeze); next state MEM_WAIT.
  3. branch_taken_mem: all en=1, pc_en=1, flush_ifid=flush_idex=flush_exmem=1; next state RUN.
  4. jump_ex: all en=1, pc_en=1, flush_ifid=flush_idex=1; next state RUN.
  5. lu_hazard & state==RUN: pc_en=0, en_ifid=0, en_idex=1 with flush_idex=1, en_exmem=en_memwb=1; next state LU_STALL.
  6. ~ihit: pc_en=0, en_ifid=0, en_idex=1 with flush_idex=1, downstream en=1.
  7. else: all en=1, pc_en=1, no flush; next state RUN.
- LU_STALL lasts exactly one cycle. lu_hazard is ignored in that state, so a second bubble is never inserted for the same load. The state exits to RUN unless a higher priority (1-2) applies.
- MEM_WAIT: freeze, same as rule 2, until dhit=1.
  - On the dhit cycle, rules 3-7 are evaluated as in RUN (lu_hazard included) and next state follows them.
  - halt_wb during MEM_WAIT still wins.
- HALT: all outputs 0 except halted=1. Only reset exits.
- Simultaneous ihit miss and lu_hazard: the lu_hazard row applies and the FSM enters LU_STALL. Its outputs are identical to the ihit-miss row.
- Flush without enable is a no-op; the controller never asserts flush_x with en_x=0.
- stall_cycles increments on every cycle where pc_en=0 and halted=0 and nRST=1. It saturates at all-ones and does not wrap.

Decomposition:
- Add typedef enum logic [1:0] hazard_state_t {RUN, LU_STALL, MEM_WAIT, HALT} to cpu_types_pkg. Use regbits_t for register selects.
- Add pipeline_hazard_ctrl_if to include/, with modports hc and tb.
- One sub-module, load_use_detect (combinational lu_hazard), reused later by the forwarding unit bench.

Test Plan:
1. Load to $5 in EX, DEC reads rs=$5, ihit=1 -> cycle0: pc_en=0, en_ifid=0, flush_idex=1, state LU_STALL. Cycle1 (same DEC inputs): all en=1, pc_en=1. stall_cycles=1.
2. dmemREN_mem=1, dhit=0 for 3 cycles then 1 -> 3 cycles all en=0, MEM_WAIT. Fourth cycle all en=1. stall_cycles=4 (the dhit cycle itself counts 0).
3. branch_taken_mem=1 with lu_hazard=1 -> flush_ifid=flush_idex=flush_exmem=1, pc_en=1, no LU_STALL entry.
4. wsel_ex=0, MemtoReg_ex=1, rs_dec=0 -> no stall: pc_en=1, all en=1.
5. halt_wb=1 during MEM_WAIT -> next cycle halted=1, all en=0. Outputs hold for 10 cycles. nRST pulse -> halted=0, state RUN.
6. Force ihit=0 for 2^16+5 cycles -> stall_cycles holds at 16'hFFFF.
